debug_reg_writer: RTL and testbench

- Input-side counterpart of the register display path: the display reads a register selected by SW; this block writes an operator-entered value into a selected register of the single-cycle RISC-V core.
- Debounces a raw push-button and latches switch address/data on a clean press.
- Halts the core through a request/acknowledge handshake, issues a one-cycle debug write to the register file, then releases the core.
- Sits in the FPGA top next to the display logic; drives the register file's debug write port.

---
 rtl/debug_reg_writer.sv | 156 +++++++++++++++
 tb/tb_debug_reg_writer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_reg_writer.sv
// Operator-driven debug write into the core register file: debounced button press
// latches switch address/data, halts the core, pulses one debug write, then releases it.
module debug_reg_writer #(
    parameter int DATA_SW_W       = 10,
    parameter int SIGN_EXT        = 0,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACK_TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_n,
    input  logic [4:0]           sw_addr,
    input  logic [DATA_SW_W-1:0] sw_data,
    input  logic                 halt_ack,
    output logic                 halt_req,
    output logic                 dbg_we,
    output logic [4:0]           dbg_waddr,
    output logic [31:0]          dbg_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           write_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, RELEASE} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            db_q, db_d, db_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [4:0]      waddr_q;
    logic [31:0]     wdata_q;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      count_q;
    logic            latch;
    logic            press;
    logic [31:0]     ext_data;

    generate
        if (SIGN_EXT != 0) begin : g_sext
            assign ext_data = {{(32-DATA_SW_W){sw_data[DATA_SW_W-1]}}, sw_data};
        end else begin : g_zext
            assign ext_data = {{(32-DATA_SW_W){1'b0}}, sw_data};
        end
    endgenerate

    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d = ~db_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign press = db_prev_q & ~db_q;

    always_comb begin
        state_d  = state_q;
        to_cnt_d = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        latch    = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    if (sw_addr == 5'd0) begin
                        err_d = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (halt_ack) begin
                    state_d = WRITE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WRITE: state_d = RELEASE;
            RELEASE: begin
                if (!halt_ack) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Debounced level resets to "pressed" so a button held through reset must be
    // released and pressed again before it can generate a press event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            to_cnt_q  <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            if (latch) begin
                waddr_q <= sw_addr;
                wdata_q <= ext_data;
            end
            if (done_d) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign halt_req    = (state_q == REQ) || (state_q == WRITE);
    assign dbg_we      = (state_q == WRITE);
    assign busy        = (state_q != IDLE);
    assign dbg_waddr   = waddr_q;
    assign dbg_wdata   = wdata_q;
    assign done        = done_q;
    assign err         = err_q;
    assign write_count = count_q;

endmodule

// File: tb/tb_debug_reg_writer.sv
// Bench for debug_reg_writer: zero- and sign-extending instances share stimulus;
// a core responder answers halt_req with programmable ack/release delays.
module tb_debug_reg_writer;

    localparam int DB = 4;
    localparam int TO = 16;

    typedef struct {
        int          btn_len;
        logic [4:0]  addr;
        logic [9:0]  data;
        int          ack_dly;
        int          rel_dly;
        bit          we;
        bit          done;
        bit          err;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        int          req_cyc;
        int          busy_cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_n;
    logic [4:0] sw_addr;
    logic [9:0] sw_data;
    logic       halt_ack;

    logic [1:0]  halt_req_w, dbg_we_w, busy_w, done_w, err_w;
    logic [4:0]  waddr_w [2];
    logic [31:0] wdata_w [2];
    logic [7:0]  wc_w [2];

    int n_checks = 0;
    int n_errors = 0;
    int ack_dly_cfg = 1;
    int rel_dly_cfg = 1;
    int exp_count = 0;

    int          we_tot [2], done_tot [2], err_tot [2], ovl_tot [2], req_tot [2], busy_tot [2];
    logic [4:0]  last_waddr [2];
    logic [31:0] last_wdata [2];

    always #5 clk = ~clk;

    debug_reg_writer #(.DATA_SW_W(10), .SIGN_EXT(0), .DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(TO)) dut0 (
        .clk(clk), .reset(reset), .btn_n(btn_n), .sw_addr(sw_addr), .sw_data(sw_data),
        .halt_ack(halt_ack), .halt_req(halt_req_w[0]), .dbg_we(dbg_we_w[0]),
        .dbg_waddr(waddr_w[0]), .dbg_wdata(wdata_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .err(err_w[0]), .write_count(wc_w[0])
    );

    debug_reg_writer #(.DATA_SW_W(10), .SIGN_EXT(1), .DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(TO)) dut1 (
        .clk(clk), .reset(reset), .btn_n(btn_n), .sw_addr(sw_addr), .sw_data(sw_data),
        .halt_ack(halt_ack), .halt_req(halt_req_w[1]), .dbg_we(dbg_we_w[1]),
        .dbg_waddr(waddr_w[1]), .dbg_wdata(wdata_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .err(err_w[1]), .write_count(wc_w[1])
    );

    initial begin
        for (int d = 0; d < 2; d++) begin
            we_tot[d] = 0; done_tot[d] = 0; err_tot[d] = 0;
            ovl_tot[d] = 0; req_tot[d] = 0; busy_tot[d] = 0;
            last_waddr[d] = '0; last_wdata[d] = '0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (dbg_we_w[d]) begin
                we_tot[d]     <= we_tot[d] + 1;
                last_waddr[d] <= waddr_w[d];
                last_wdata[d] <= wdata_w[d];
            end
            if (done_w[d]) done_tot[d] <= done_tot[d] + 1;
            if (err_w[d]) err_tot[d] <= err_tot[d] + 1;
            if (done_w[d] && err_w[d]) ovl_tot[d] <= ovl_tot[d] + 1;
            if (halt_req_w[d]) req_tot[d] <= req_tot[d] + 1;
            if (busy_w[d]) busy_tot[d] <= busy_tot[d] + 1;
        end
    end

    // Core model: acks after ack_dly_cfg cycles of halt_req, drops ack after rel_dly_cfg cycles of release.
    initial begin
        int a_cnt, r_cnt;
        halt_ack = 1'b0;
        a_cnt = 0;
        r_cnt = 0;
        forever begin
            @(negedge clk);
            if (!halt_ack) begin
                if (halt_req_w[0]) begin
                    a_cnt++;
                    if (a_cnt >= ack_dly_cfg) begin
                        halt_ack = 1'b1;
                        a_cnt = 0;
                    end
                end else begin
                    a_cnt = 0;
                end
            end else begin
                if (!halt_req_w[0]) begin
                    r_cnt++;
                    if (r_cnt >= rel_dly_cfg) begin
                        halt_ack = 1'b0;
                        r_cnt = 0;
                    end
                end else begin
                    r_cnt = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (dut%0d): got %0h expected %0h", name, d, act, exp);
        end
    endtask

    function automatic vec_t predict(input int btn_len, input logic [4:0] addr, input logic [9:0] data,
                                     input int ack_dly, input int rel_dly);
        vec_t v;
        v.btn_len = btn_len; v.addr = addr; v.data = data;
        v.ack_dly = ack_dly; v.rel_dly = rel_dly;
        v.we = 0; v.done = 0; v.err = 0;
        v.wdata0 = 0; v.wdata1 = 0; v.req_cyc = 0; v.busy_cyc = 0;
        if (btn_len >= DB) begin
            if (addr == 0) begin
                v.err = 1;
            end else if (ack_dly > TO) begin
                v.err = 1;
                v.req_cyc = TO;
                v.busy_cyc = TO;
            end else begin
                v.we = 1;
                v.wdata0 = 32'(data);
                v.wdata1 = data[9] ? (32'hFFFF_FC00 | 32'(data)) : 32'(data);
                v.req_cyc = ack_dly + 1;
                if (rel_dly > TO) begin
                    v.err = 1;
                    v.busy_cyc = v.req_cyc + TO;
                end else begin
                    v.done = 1;
                    v.busy_cyc = v.req_cyc + rel_dly;
                end
            end
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int we0 [2], dn0 [2], er0 [2], ov0 [2], rq0 [2], bz0 [2];
        ack_dly_cfg = v.ack_dly;
        rel_dly_cfg = v.rel_dly;
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            we0[d] = we_tot[d]; dn0[d] = done_tot[d]; er0[d] = err_tot[d];
            ov0[d] = ovl_tot[d]; rq0[d] = req_tot[d]; bz0[d] = busy_tot[d];
        end
        sw_addr = v.addr;
        sw_data = v.data;
        btn_n = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c == v.btn_len) btn_n = 1'b1;
            if (c == 8) sw_data = ~v.data;
            if (c == 9) sw_addr = ~v.addr;
        end
        #1;
        if (v.done) exp_count = (exp_count + 1) % 256;
        for (int d = 0; d < 2; d++) begin
            chk("we_pulses", d, 32'(we_tot[d] - we0[d]), 32'(v.we));
            if (v.we) begin
                chk("waddr", d, 32'(last_waddr[d]), 32'(v.addr));
                chk("wdata", d, last_wdata[d], (d == 0) ? v.wdata0 : v.wdata1);
            end
            chk("done_pulses", d, 32'(done_tot[d] - dn0[d]), 32'(v.done));
            chk("err_pulses", d, 32'(err_tot[d] - er0[d]), 32'(v.err));
            chk("done_err_overlap", d, 32'(ovl_tot[d] - ov0[d]), 32'd0);
            chk("halt_req_cycles", d, 32'(req_tot[d] - rq0[d]), 32'(v.req_cyc));
            chk("busy_cycles", d, 32'(busy_tot[d] - bz0[d]), 32'(v.busy_cyc));
            chk("write_count", d, 32'(wc_w[d]), 32'(exp_count));
            chk("idle_at_end", d, 32'(busy_w[d]), 32'd0);
        end
        $display("txn %0d: btn=%0d addr=%0d data=%03h ack=%0d rel=%0d exp we=%0d done=%0d err=%0d count=%0d",
                 idx, v.btn_len, v.addr, v.data, v.ack_dly, v.rel_dly, v.we, v.done, v.err, exp_count);
    endtask

    vec_t tbl [10];

    initial begin
        vec_t v;
        int seen;
        int rq0, er0, bz0;

        tbl[0] = '{2, 5'd8,  10'h3FF, 1,  1,  0, 0, 0, 32'h0,         32'h0,         0,  0};
        tbl[1] = '{3, 5'd8,  10'h3FF, 1,  1,  0, 0, 0, 32'h0,         32'h0,         0,  0};
        tbl[2] = '{6, 5'd8,  10'h3FF, 1,  1,  1, 1, 0, 32'h0000_03FF, 32'hFFFF_FFFF, 2,  3};
        tbl[3] = '{6, 5'd9,  10'h200, 3,  2,  1, 1, 0, 32'h0000_0200, 32'hFFFF_FE00, 4,  6};
        tbl[4] = '{6, 5'd0,  10'h155, 1,  1,  0, 0, 1, 32'h0,         32'h0,         0,  0};
        tbl[5] = '{6, 5'd12, 10'h0AB, 17, 1,  0, 0, 1, 32'h0,         32'h0,         16, 16};
        tbl[6] = '{6, 5'd3,  10'h07F, 1,  1,  1, 1, 0, 32'h0000_007F, 32'h0000_007F, 2,  3};
        tbl[7] = '{4, 5'd17, 10'h1FF, 16, 1,  1, 1, 0, 32'h0000_01FF, 32'h0000_01FF, 17, 18};
        tbl[8] = '{6, 5'd31, 10'h2AA, 2,  17, 1, 0, 1, 32'h0000_02AA, 32'hFFFF_FEAA, 3,  19};
        tbl[9] = '{6, 5'd1,  10'h001, 1,  16, 1, 1, 0, 32'h0000_0001, 32'h0000_0001, 2,  18};

        reset = 1'b0;
        btn_n = 1'b1;
        sw_addr = '0;
        sw_data = '0;
        repeat (4) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_halt_req", d, 32'(halt_req_w[d]), 32'd0);
            chk("rst_dbg_we", d, 32'(dbg_we_w[d]), 32'd0);
            chk("rst_busy_done_err", d, 32'({busy_w[d], done_w[d], err_w[d]}), 32'd0);
            chk("rst_waddr", d, 32'(waddr_w[d]), 32'd0);
            chk("rst_wdata", d, wdata_w[d], 32'd0);
            chk("rst_write_count", d, 32'(wc_w[d]), 32'd0);
        end
        reset = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // Reset while waiting for ack, with the button still held down.
        ack_dly_cfg = 1000;
        rel_dly_cfg = 1;
        @(negedge clk);
        sw_addr = 5'd5;
        sw_data = 10'h123;
        btn_n = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (halt_req_w[0]) seen = 1;
        end
        chk("req_before_reset", 0, 32'(seen), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("midrst_halt_req", d, 32'(halt_req_w[d]), 32'd0);
            chk("midrst_busy", d, 32'(busy_w[d]), 32'd0);
            chk("midrst_write_count", d, 32'(wc_w[d]), 32'd0);
            chk("midrst_dbg_we", d, 32'(dbg_we_w[d]), 32'd0);
        end
        reset = 1'b1;
        exp_count = 0;
        #1;
        rq0 = req_tot[0]; er0 = err_tot[0]; bz0 = busy_tot[0];
        repeat (30) @(negedge clk);
        #1;
        chk("held_btn_no_req", 0, 32'(req_tot[0] - rq0), 32'd0);
        chk("held_btn_no_err", 0, 32'(err_tot[0] - er0), 32'd0);
        chk("held_btn_no_busy", 0, 32'(busy_tot[0] - bz0), 32'd0);
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
        run_vec(tbl[3], 10);

        for (int i = 0; i < 24; i++) begin
            int bl, ad, ak, rl;
            logic [4:0] a;
            bl = int'($urandom_range(2, 8));
            a  = ($urandom_range(0, 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ak = int'($urandom_range(1, 20));
            rl = int'($urandom_range(1, 20));
            ad = int'($urandom_range(0, 1023));
            v = predict(bl, a, 10'(ad), ak, rl);
            run_vec(v, 11 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
